// File: rtl/adc_min_window_pkg.sv
// -----------------------------------------------------------------------------
// adc_min_window_pkg
// Shared definitions for the ADC minimum measurement-window controller.
// Contents:
//   win_state_t        controller state encoding (IDLE / SETTLE / MEASURE)
//   DEFAULT_PIPE_LAT   default settle length, matches the upstream min pipeline
//   ACC_INIT_ALL       running-minimum start value; sliced down to the sample
//                      width by each user (sample widths up to 32 bits)
// -----------------------------------------------------------------------------
package adc_min_window_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2
   } win_state_t;

   localparam int DEFAULT_PIPE_LAT   = 3;
   localparam int MAX_ADC_DATA_WIDTH = 32;

   // All-ones is the identity for an unsigned minimum.
   localparam logic [MAX_ADC_DATA_WIDTH-1:0] ACC_INIT_ALL = '1;

endpackage

// File: rtl/adc_min_accum.sv
// -----------------------------------------------------------------------------
// adc_min_accum
// One running-minimum register for a single core's sample stream.
// Ports:
//   clk       clock
//   rst       synchronous, active-high reset (register goes to all-ones)
//   load      reload register with all-ones (has priority over en)
//   en        fold the current sample into the running minimum
//   sample    unsigned sample for this cycle
//   next_min  combinational min(register, sample); lets the owner capture a
//             window result that already includes the sample of this cycle
// -----------------------------------------------------------------------------
module adc_min_accum
   import adc_min_window_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] sample,
   output logic [W-1:0] next_min
);

   localparam logic [W-1:0] INIT = ACC_INIT_ALL[W-1:0];

   logic [W-1:0] acc;

   assign next_min = (sample < acc) ? sample : acc;

   always_ff @(posedge clk) begin
      // NOTE: the accumulator is reset even though every window reloads it,
      // so the register never holds X if a result is read straight after reset.
      if (rst) begin
         acc <= INIT;
      end else if (load) begin
         acc <= INIT;
      end else if (en) begin
         acc <= next_min;
      end
   end

endmodule

// File: rtl/adc_min_window_ctrl.sv
// -----------------------------------------------------------------------------
// adc_min_window_ctrl
// Sequences four per-core minimum streams into gap-free measurement windows,
// reduces each core to one minimum per window and presents the results to the
// host through a valid/ack handshake.
// Parameters:
//   ADC_DATA_WIDTH  sample width (unsigned, offset binary)
//   WIN_CNT_WIDTH   window-length counter width
//   PIPE_LAT        settle cycles after start (must be >= 1)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i                  start pulse, honoured only in IDLE
//   stop_i                   abort; drops the partial window
//   continuous_i             run windows back-to-back until stop_i
//   win_len_i                window length in samples (0 acts as 1)
//   adc_min_A_i..D_i         per-core minimum streams, one value per cycle
//   meas_ack_i               host acknowledge of the current result
//   meas_valid_o             unacknowledged result present
//   min_A_o..min_D_o         window minimum per core
//   busy_o                   controller not in IDLE
//   overrun_o                sticky: a window ended while a result was pending
// -----------------------------------------------------------------------------
module adc_min_window_ctrl
   import adc_min_window_pkg::*;
#(
   parameter int ADC_DATA_WIDTH = 8,
   parameter int WIN_CNT_WIDTH  = 24,
   parameter int PIPE_LAT       = DEFAULT_PIPE_LAT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      stop_i,
   input  logic                      continuous_i,
   input  logic [WIN_CNT_WIDTH-1:0]  win_len_i,
   input  logic [ADC_DATA_WIDTH-1:0] adc_min_A_i,
   input  logic [ADC_DATA_WIDTH-1:0] adc_min_B_i,
   input  logic [ADC_DATA_WIDTH-1:0] adc_min_C_i,
   input  logic [ADC_DATA_WIDTH-1:0] adc_min_D_i,
   input  logic                      meas_ack_i,
   output logic                      meas_valid_o,
   output logic [ADC_DATA_WIDTH-1:0] min_A_o,
   output logic [ADC_DATA_WIDTH-1:0] min_B_o,
   output logic [ADC_DATA_WIDTH-1:0] min_C_o,
   output logic [ADC_DATA_WIDTH-1:0] min_D_o,
   output logic                      busy_o,
   output logic                      overrun_o
);

   localparam int NUM_CORES = 4;
   localparam int SETTLE_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   win_state_t                state;
   logic [SETTLE_W-1:0]       settle_cnt;
   logic [WIN_CNT_WIDTH-1:0]  sample_cnt;
   logic [WIN_CNT_WIDTH-1:0]  win_len_q;
   logic [WIN_CNT_WIDTH-1:0]  win_len_eff;
   logic                      settle_done;
   logic                      win_end;
   logic                      acc_load;
   logic                      acc_en;
   logic                      result_load;

   logic [ADC_DATA_WIDTH-1:0] sample   [NUM_CORES];
   logic [ADC_DATA_WIDTH-1:0] next_min [NUM_CORES];

   assign sample[0] = adc_min_A_i;
   assign sample[1] = adc_min_B_i;
   assign sample[2] = adc_min_C_i;
   assign sample[3] = adc_min_D_i;

   // A zero length is folded to one sample so the window always terminates.
   assign win_len_eff = (win_len_i == '0) ? WIN_CNT_WIDTH'(1) : win_len_i;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      settle_done = 1'b0;
      win_end     = 1'b0;
      if (state == ST_SETTLE) begin
         settle_done = (settle_cnt == SETTLE_W'(PIPE_LAT - 1));
      end
      if (state == ST_MEASURE) begin
         win_end = (sample_cnt == win_len_q - WIN_CNT_WIDTH'(1));
      end
   end

   // Reloading on every window end is harmless when the block then goes idle.
   assign acc_load    = settle_done | win_end;
   assign acc_en      = (state == ST_MEASURE);
   // A result is taken when the register is free or freed in the same cycle.
   assign result_load = win_end & (~meas_valid_o | meas_ack_i);

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
      adc_min_accum #(
         .W (ADC_DATA_WIDTH)
      ) u_accum (
         .clk      (clk),
         .rst      (rst),
         .load     (acc_load),
         .en       (acc_en),
         .sample   (sample[g]),
         .next_min (next_min[g])
      );
   end

   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state        <= ST_IDLE;
         settle_cnt   <= '0;
         sample_cnt   <= '0;
         win_len_q    <= WIN_CNT_WIDTH'(1);
         meas_valid_o <= 1'b0;
         min_A_o      <= '0;
         min_B_o      <= '0;
         min_C_o      <= '0;
         min_D_o      <= '0;
         busy_o       <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         // Host ack retires the pending result; a window-end load below
         // overrides this and keeps valid high with the new data.
         if (meas_ack_i && meas_valid_o) begin
            meas_valid_o <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               // stop_i in IDLE wins over a simultaneous start_i.
               if (start_i && !stop_i) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= '0;
                  overrun_o  <= 1'b0;
                  busy_o     <= 1'b1;
               end
            end

            ST_SETTLE: begin
               if (stop_i) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end else if (settle_done) begin
                  state      <= ST_MEASURE;
                  win_len_q  <= win_len_eff;
                  sample_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + SETTLE_W'(1);
               end
            end

            ST_MEASURE: begin
               if (win_end) begin
                  if (result_load) begin
                     min_A_o      <= next_min[0];
                     min_B_o      <= next_min[1];
                     min_C_o      <= next_min[2];
                     min_D_o      <= next_min[3];
                     meas_valid_o <= 1'b1;
                  end else begin
                     overrun_o <= 1'b1;
                  end
                  // The result of this window is delivered even when stopping.
                  if (continuous_i && !stop_i) begin
                     win_len_q  <= win_len_eff;
                     sample_cnt <= '0;
                  end else begin
                     state  <= ST_IDLE;
                     busy_o <= 1'b0;
                  end
               end else if (stop_i) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end else begin
                  sample_cnt <= sample_cnt + WIN_CNT_WIDTH'(1);
               end
            end

            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
